// File: rtl/keypad_scan_if.sv
// Keypad scanner bundle: the active-low matrix lines plus the debounced key event toward the clock controller.
interface keypad_scan_if;
  logic [3:0] i_col;
  logic [3:0] o_row;
  logic [3:0] o_key_code;
  logic       o_key_valid;
  logic       o_key_held;
  logic       o_multi;

  modport master (
    input  i_col,
    output o_row, o_key_code, o_key_valid, o_key_held, o_multi
  );

  modport slave (
    output i_col,
    input  o_row, o_key_code, o_key_valid, o_key_held, o_multi
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates active-low row strobes, classifies each complete frame,
// and debounces presses/releases at frame granularity into a one-cycle key event.
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  // Number of pressed keys in one row, saturated at 2 ("many").
  function automatic logic [1:0] row_hits(input logic [3:0] p);
    logic [2:0] n;
    n = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] first_col(input logic [3:0] p);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) c = 2'(i);
    end
    return c;
  endfunction

  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd1) ? 2'd2 : s[1:0];
  endfunction

  // Column synchroniser (data path, free-running)
  logic [3:0] col_meta_q, col_sync_q;

  always_ff @(posedge clk) begin
    col_meta_q <= kp.i_col;
    col_sync_q <= col_meta_q;
  end

  // Slot timing and row rotation
  logic [CNT_W-1:0] slot_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic             slot_last;

  assign slot_last = (slot_q == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      row_idx_q <= 2'd0;
      row_q     <= 4'b1110;
    end else if (slot_last) begin
      slot_q    <= '0;
      row_idx_q <= row_idx_q + 2'd1;
      row_q     <= {row_q[2:0], row_q[3]};
    end else begin
      slot_q    <= slot_q + CNT_W'(1);
    end
  end

  // Frame accumulation: running key count and the code of the first key seen
  logic [3:0] pressed;
  logic [1:0] hits;
  logic [1:0] acc_cnt_q, acc_cnt_d;
  logic [3:0] acc_key_q, acc_key_d;
  logic       frame_vld_q;
  cls_e       frame_cls_q;
  logic [3:0] frame_key_q;

  assign pressed = ~col_sync_q;
  assign hits    = row_hits(pressed);

  always_comb begin
    acc_cnt_d = sat_add(acc_cnt_q, hits);
    acc_key_d = acc_key_q;
    if (acc_cnt_q == 2'd0 && hits == 2'd1) acc_key_d = {row_idx_q, first_col(pressed)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q   <= 2'd0;
      acc_key_q   <= 4'd0;
      frame_vld_q <= 1'b0;
      frame_cls_q <= CLS_NONE;
      frame_key_q <= 4'd0;
    end else begin
      frame_vld_q <= 1'b0;
      if (slot_last) begin
        if (row_idx_q == 2'd3) begin
          frame_vld_q <= 1'b1;
          frame_cls_q <= cls_e'(acc_cnt_d);
          frame_key_q <= acc_key_d;
          acc_cnt_q   <= 2'd0;
          acc_key_q   <= 4'd0;
        end else begin
          acc_cnt_q   <= acc_cnt_d;
          acc_key_q   <= acc_key_d;
        end
      end
    end
  end

  // Debounce FSM, stepped once per completed frame
  state_e            state_q;
  logic [3:0]        cand_q;
  logic [STAB_W-1:0] stab_q, rel_q, stab_inc, rel_inc;
  logic [3:0]        key_code_q;
  logic              key_valid_q, key_held_q, multi_q;

  assign stab_inc = stab_q + STAB_W'(1);
  assign rel_inc  = rel_q + STAB_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      stab_q      <= '0;
      rel_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_vld_q) begin
        multi_q <= (frame_cls_q == CLS_MULTI);
        case (state_q)
          IDLE: begin
            if (frame_cls_q == CLS_SINGLE) begin
              cand_q  <= frame_key_q;
              stab_q  <= STAB_W'(1);
              state_q <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (frame_cls_q != CLS_SINGLE) begin
              stab_q  <= '0;
              state_q <= IDLE;
            end else if (frame_key_q != cand_q) begin
              cand_q  <= frame_key_q;
              stab_q  <= STAB_W'(1);
            end else if (stab_inc == STAB_W'(DEBOUNCE_CNT)) begin
              key_code_q  <= cand_q;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              stab_q      <= '0;
              state_q     <= HELD;
            end else begin
              stab_q  <= stab_inc;
            end
          end
          // Any key activity while held is locked out; only a clean NONE starts release.
          HELD: begin
            if (frame_cls_q == CLS_NONE) begin
              rel_q   <= STAB_W'(1);
              state_q <= RELEASE;
            end
          end
          RELEASE: begin
            if (frame_cls_q != CLS_NONE) begin
              rel_q   <= '0;
              state_q <= HELD;
            end else if (rel_inc == STAB_W'(DEBOUNCE_CNT)) begin
              rel_q      <= '0;
              key_held_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              rel_q   <= rel_inc;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign kp.o_row       = row_q;
  assign kp.o_key_code  = key_code_q;
  assign kp.o_key_valid = key_valid_q;
  assign kp.o_key_held  = key_held_q;
  assign kp.o_multi     = multi_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: switch matrix model driven from o_row, hand-computed event timing.
module tb_keypad_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys = 16'h0000;

  keypad_scan_if kp ();

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.master)
  );

  always #5 clk = ~clk;

  // Closed switch at (r,c) pulls column c low while row r is strobed.
  always_comb begin
    logic [3:0] col;
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.o_row[r] && keys[r*4+c]) col[c] = 1'b0;
    kp.i_col = col;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  int n_pulse, pulse_cyc, pulse_code;
  bit held_hi, held_lo, multi_hi, dbl, prev_v;
  logic [3:0] row_exp [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_pulse = 0; pulse_cyc = -1; pulse_code = -1;
    held_hi = 0; held_lo = 0; multi_hi = 0; dbl = 0;
  endtask

  // Advance n cycles; cyc is the index of the cycle being observed (#1 after its starting edge).
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (kp.o_key_valid) begin
        if (prev_v) dbl = 1;
        n_pulse++;
        pulse_cyc  = cyc;
        pulse_code = kp.o_key_code;
      end
      prev_v = kp.o_key_valid;
      if (kp.o_key_held) held_hi = 1; else held_lo = 1;
      if (kp.o_multi) multi_hi = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    prev_v = 0;
    clr();
  endtask

  initial begin
    row_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // 1: idle scan
    keys = 16'h0000;
    do_reset();
    check("t1_row0", kp.o_row, 4'b1110);
    check("t1_outs", {kp.o_key_code, kp.o_key_valid, kp.o_key_held, kp.o_multi}, 7'd0);
    for (int k = 1; k <= 4; k++) begin
      run(4);
      check($sformatf("t1_row_slot%0d", k), kp.o_row, row_exp[k % 4]);
    end
    run(160 - 16);
    check("t1_pulses", n_pulse, 0);
    check("t1_held", held_hi, 0);
    check("t1_multi", multi_hi, 0);

    // 2: key 9 held from reset, accepted one cycle after 3rd frame end (cycle 49)
    keys = 16'h0000; keys[9] = 1'b1;
    do_reset();
    run(48);
    check("t2_early", n_pulse, 0);
    run(1);
    check("t2_valid", kp.o_key_valid, 1);
    check("t2_code", kp.o_key_code, 9);
    check("t2_held", kp.o_key_held, 1);
    run(1);
    check("t2_valid_1cyc", kp.o_key_valid, 0);
    clr();
    run(160);
    check("t2_no_more", n_pulse, 0);
    check("t2_held_stays", held_lo, 0);

    // 3: bounce 2 present, 1 absent, 3 present -> event at cycle 97
    keys = 16'h0000; keys[9] = 1'b1;
    do_reset();
    run(32);
    keys[9] = 1'b0;
    run(16);
    keys[9] = 1'b1;
    run(72);
    check("t3_pulses", n_pulse, 1);
    check("t3_pulse_cyc", pulse_cyc, 97);
    check("t3_code", pulse_code, 9);

    // 4: keys 0 and 5 together for 5 frames
    keys = 16'h0000; keys[0] = 1'b1; keys[5] = 1'b1;
    do_reset();
    run(16);
    check("t4_multi_before", kp.o_multi, 0);
    run(1);
    check("t4_multi_set", kp.o_multi, 1);
    run(63);
    keys = 16'h0000;
    run(16);
    check("t4_multi_hold", kp.o_multi, 1);
    run(1);
    check("t4_multi_clear", kp.o_multi, 0);
    check("t4_pulses", n_pulse, 0);
    check("t4_held", held_hi, 0);

    // 5: release debounce, re-press lockout, then key 3
    keys = 16'h0000; keys[9] = 1'b1;
    do_reset();
    run(49);
    check("t5_accept", kp.o_key_valid, 1);
    clr();
    run(15);
    keys[9] = 1'b0;
    run(32);
    keys[9] = 1'b1;
    run(32);
    keys[9] = 1'b0;
    run(48);
    check("t5_held_before_drop", kp.o_key_held, 1);
    check("t5_no_repress_event", n_pulse, 0);
    check("t5_held_never_low", held_lo, 0);
    run(1);
    check("t5_held_drop", kp.o_key_held, 0);
    keys[3] = 1'b1;
    run(47);
    check("t5_key3_early", n_pulse, 0);
    run(1);
    check("t5_key3_valid", kp.o_key_valid, 1);
    check("t5_key3_code", kp.o_key_code, 3);

    // 6: reset mid-debounce (stab=2), key stays pressed
    keys = 16'h0000; keys[9] = 1'b1;
    do_reset();
    run(40);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("t6_row_reset", kp.o_row, 4'b1110);
    check("t6_outs_reset", {kp.o_key_code, kp.o_key_valid, kp.o_key_held, kp.o_multi}, 7'd0);
    check("t6_no_pulse_pre", n_pulse, 0);
    cyc = 0;
    clr();
    run(48);
    check("t6_early", n_pulse, 0);
    run(1);
    check("t6_valid", kp.o_key_valid, 1);
    check("t6_code", kp.o_key_code, 9);
    check("t6_no_back_to_back", dbl, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scanning input front-end for a 4x4 matrix keypad used to enter clock setup values.
- It is the input-direction counterpart of the multiplexed seven-segment display driver. It drives one active-low row strobe at a time and samples the active-low columns.
- It debounces at scan-frame granularity and emits a one-cycle key event with a 4-bit key code to the clock controller.

Parameters:
- SCAN_DIV, 50000, clk cycles per row slot (1 kHz slot rate at 50 MHz clk); legal range >= 4.
- DEBOUNCE_CNT, 4, consecutive identical complete frames required to accept a press or a release; legal range >= 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- i_col  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
- o_row  output  4  row strobes, active-low one-hot; bit r drives row r.
- o_key_code  output  4  code of the last accepted key = row*4 + col.
- o_key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- o_key_held  output  1  level; high from acceptance until the debounced release.
- o_multi  output  1  level; high when the last completed frame saw 2 or more pressed keys.

Behaviour:
- Reset values:
  - o_row=4'b1110.
  - o_key_code=0, o_key_valid=0, o_key_held=0, o_multi=0.
  - Slot counter 0, row index 0, FSM IDLE, all frame, stability and release counters 0.
- Synchronous reset asserted at any time, including mid-frame or mid-debounce, aborts all activity; no o_key_valid is produced.
- Column synchroniser:
  - i_col passes through a 2-flop synchroniser before use.
  - Effective column latency is 2 cycles. SCAN_DIV >= 4 guarantees the sample reflects the currently driven row.
- Slot timing:
  - The slot counter runs 0..SCAN_DIV-1 and wraps.
  - On the cycle where the counter = SCAN_DIV-1, the synchronised columns are captured for the current row.
  - On the next cycle the row index advances r -> r+1 (3 wraps to 0) and o_row rotates 1110->1101->1011->0111->1110.
- Frame:
  - A frame is 4 consecutive slots, rows 0..3, so one frame = 4*SCAN_DIV cycles.
  - When row 3 is captured, the frame is classified as NONE (0 keys), SINGLE(K) (exactly 1 key, K = row*4 + col) or MULTI (>=2 keys).
  - o_multi is updated with the classification on the same cycle as the FSM step.
  - The FSM steps once per frame, on the cycle after the row-3 capture.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - SINGLE(K): cand=K, stab=1, go to DEBOUNCE.
  - NONE or MULTI: stay in IDLE.
- DEBOUNCE:
  - SINGLE(cand): stab+1. When stab reaches DEBOUNCE_CNT, set o_key_code=cand, pulse o_key_valid for exactly 1 cycle, set o_key_held=1, go to HELD.
  - SINGLE(K != cand): cand=K, stab=1, stay in DEBOUNCE.
  - NONE or MULTI: go to IDLE.
- HELD:
  - NONE: rel=1, go to RELEASE.
  - SINGLE (any key) or MULTI: stay in HELD. No new event (n-key lockout); o_key_code is unchanged.
- RELEASE:
  - NONE: rel+1. When rel reaches DEBOUNCE_CNT, o_key_held=0 and go to IDLE.
  - Any key: go back to HELD with rel=0; no new event.
- Latency: an ideal press produces o_key_valid at the end of the DEBOUNCE_CNT-th complete frame containing the key, +1 cycle.
- o_key_valid is never high on two consecutive cycles. At most one o_key_valid is produced per HELD episode.
- A press starting mid-frame counts only from the first full frame in which it is sampled.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 cycles; the bench drives i_col combinationally from o_row to model switches):
1. Reset then idle, i_col=4'b1111:
   - o_row steps 1110,1101,1011,0111,1110 every 4 cycles.
   - o_key_valid, o_key_held and o_multi remain 0 for 10 frames.
2. Key at row 2, col 1 held (i_col=4'b1101 while o_row=1011):
   - Exactly one 1-cycle o_key_valid with o_key_code=9, 1 cycle after the 3rd frame end.
   - o_key_held=1 thereafter.
   - No further pulses over 10 more frames.
3. Bounce, key 9 present 2 frames, absent 1, present 3 frames:
   - Exactly one o_key_valid, after the 3rd frame of the final run.
4. Keys 0 (row 0, col 0) and 5 (row 1, col 1) pressed together for 5 frames:
   - o_multi=1 from the first frame end.
   - No o_key_valid and o_key_held=0.
   - o_multi returns to 0 after the first NONE frame.
5. Release debounce:
   - After key 9 is accepted, release for 2 frames, then re-press: no new o_key_valid and o_key_held stays 1.
   - Then release for 3 frames: o_key_held falls at the 3rd frame end.
   - Then re-press key 3: new o_key_valid with o_key_code=3 after 3 frames.
6. rst asserted for 1 cycle during DEBOUNCE (stab=2):
   - Next cycle o_row=1110 and all outputs are 0.
   - No o_key_valid until 3 full new frames with the key present.
